// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB completion arbiter.
// Source order is fixed: ALU_1..3, LS_1..2, MULT_1..2, BRANCH.
package cdb_arbiter_pkg;

    localparam int N_SRC = 8;
    localparam int CDB_W = 3;
    localparam int PRW   = 6;
    localparam int ROBW  = 5;
    localparam int RR_W  = $clog2(N_SRC);

    typedef enum logic [RR_W-1:0] {
        ALU_1,
        ALU_2,
        ALU_3,
        LS_1,
        LS_2,
        MULT_1,
        MULT_2,
        BRANCH
    } fu_idx_e;

    // Broadcast tags for the three CDB slots; a tag of 0 means no wakeup.
    typedef struct packed {
        logic [PRW-1:0] t2;
        logic [PRW-1:0] t1;
        logic [PRW-1:0] t0;
    } CDB_T_PACKET;

    typedef struct packed {
        logic            valid;
        logic [PRW-1:0]  pr;
        logic [ROBW-1:0] rob;
    } FU_DONE_PACKET;

    function automatic logic [RR_W-1:0] onehot_to_idx(input logic [N_SRC-1:0] oh);
        logic [RR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (oh[i]) begin
                idx = RR_W'(i);
            end
        end
        return idx;
    endfunction

    // Wraps exactly at N_SRC-1, so it stays correct if N_SRC is not a power of two.
    function automatic logic [RR_W-1:0] next_src(input logic [RR_W-1:0] idx);
        return (idx == RR_W'(N_SRC - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_select3.sv
// Round-robin pick of up to three valid sources, starting the scan at rr_ptr.
// Rotate so rr_ptr sits at bit 0, peel off the lowest set bits, then rotate back.
module rr_select3
    import cdb_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0]              valid,
    input  logic [RR_W-1:0]               rr_ptr,
    output logic [CDB_W-1:0][N_SRC-1:0]   grant,
    output logic [CDB_W-1:0]              grant_valid,
    output logic [RR_W-1:0]               last_idx
);

    logic [2*N_SRC-1:0]            valid_dbl;
    logic [N_SRC-1:0]              remaining;
    logic [CDB_W-1:0][N_SRC-1:0]   sel_rot;
    logic [2*N_SRC-1:0]            grant_dbl;
    logic                          found;

    // NOTE: every always_comb target gets a default before any conditional
    // assignment, so no path leaves it holding an old value (no latch).
    always_comb begin
        valid_dbl   = {valid, valid} >> rr_ptr;
        remaining   = valid_dbl[N_SRC-1:0];
        sel_rot     = '0;
        grant       = '0;
        grant_valid = '0;
        grant_dbl   = '0;
        found       = 1'b0;

        for (int k = 0; k < CDB_W; k++) begin
            found = 1'b0;
            for (int j = 0; j < N_SRC; j++) begin
                if (remaining[j] && !found) begin
                    sel_rot[k][j] = 1'b1;
                    found         = 1'b1;
                end
            end
            remaining      = remaining & ~sel_rot[k];
            grant_valid[k] = |sel_rot[k];
            grant_dbl      = {sel_rot[k], sel_rot[k]} << rr_ptr;
            grant[k]       = grant_dbl[2*N_SRC-1:N_SRC];
        end
    end

    // Slots fill in scan order, so the highest valid slot holds the last grant.
    always_comb begin
        last_idx = '0;
        for (int k = 0; k < CDB_W; k++) begin
            if (grant_valid[k]) begin
                last_idx = onehot_to_idx(grant[k]);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB completion arbiter: one-entry buffer per FU, three round-robin grants per
// cycle, registered tag broadcast and ROB completion indices.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic [N_SRC-1:0]              fu_done_valid,
    input  logic [N_SRC-1:0][PRW-1:0]     fu_done_pr,
    input  logic [N_SRC-1:0][ROBW-1:0]    fu_done_rob,
    output logic [N_SRC-1:0]              fu_done_ready,
    output CDB_T_PACKET                   cdb_t,
    output logic [CDB_W-1:0]              cdb_rob_valid,
    output logic [CDB_W-1:0][ROBW-1:0]    cdb_rob_idx
);

    logic [N_SRC-1:0]              buf_valid;
    logic [PRW-1:0]                buf_pr  [N_SRC];
    logic [ROBW-1:0]               buf_rob [N_SRC];
    logic [RR_W-1:0]               rr_ptr;

    FU_DONE_PACKET                 fu_in [N_SRC];
    logic [N_SRC-1:0]              accept;
    logic [CDB_W-1:0][N_SRC-1:0]   grant;
    logic [CDB_W-1:0]              grant_valid;
    logic [RR_W-1:0]               last_idx;
    logic [N_SRC-1:0]              grant_any;
    logic [PRW-1:0]                slot_pr  [CDB_W];
    logic [ROBW-1:0]               slot_rob [CDB_W];

    rr_select3 u_select (
        .valid       (buf_valid),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid),
        .last_idx    (last_idx)
    );

    always_comb begin
        grant_any = '0;
        for (int k = 0; k < CDB_W; k++) begin
            grant_any = grant_any | grant[k];
        end
    end

    // A granted buffer frees up this cycle, so it can refill without a bubble.
    assign fu_done_ready = squash ? '0 : (~buf_valid | grant_any);

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            fu_in[i] = '{valid: fu_done_valid[i], pr: fu_done_pr[i], rob: fu_done_rob[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            accept[i] = fu_in[i].valid & fu_done_ready[i];
        end
    end

    // Grants are one-hot per slot, so an AND-OR mux picks the granted buffer.
    always_comb begin
        for (int k = 0; k < CDB_W; k++) begin
            slot_pr[k]  = '0;
            slot_rob[k] = '0;
            for (int i = 0; i < N_SRC; i++) begin
                if (grant[k][i]) begin
                    slot_pr[k]  = slot_pr[k]  | buf_pr[i];
                    slot_rob[k] = slot_rob[k] | buf_rob[i];
                end
            end
        end
    end

    // NOTE: sequential state is written with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            buf_valid <= '0;
        end else begin
            buf_valid <= accept | (buf_valid & ~grant_any);
        end
    end

    // NOTE: buffer payload has no reset; buf_valid alone qualifies it, which
    // keeps reset fan-out off the data storage.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (accept[i]) begin
                buf_pr[i]  <= fu_in[i].pr;
                buf_rob[i] <= fu_in[i].rob;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || squash) begin
            rr_ptr <= '0;
        end else if (|grant_valid) begin
            rr_ptr <= next_src(last_idx);
        end
    end

    // A squash drops the pending broadcast together with the buffers.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            cdb_t         <= '0;
            cdb_rob_valid <= '0;
            cdb_rob_idx   <= '0;
        end else begin
            cdb_t         <= '{t2: slot_pr[2], t1: slot_pr[1], t0: slot_pr[0]};
            cdb_rob_valid <= grant_valid;
            for (int k = 0; k < CDB_W; k++) begin
                cdb_rob_idx[k] <= slot_rob[k];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios, then random traffic,
// all compared against a scan-list reference model of the arbitration rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int S_ALU_2  = int'(ALU_2);
    localparam int S_MULT_1 = int'(MULT_1);

    logic                        clock = 1'b0;
    logic                        reset;
    logic                        squash;
    logic [N_SRC-1:0]            fu_done_valid;
    logic [N_SRC-1:0][PRW-1:0]   fu_done_pr;
    logic [N_SRC-1:0][ROBW-1:0]  fu_done_rob;
    logic [N_SRC-1:0]            fu_done_ready;
    CDB_T_PACKET                 cdb_t;
    logic [CDB_W-1:0]            cdb_rob_valid;
    logic [CDB_W-1:0][ROBW-1:0]  cdb_rob_idx;

    always #5 clock = ~clock;

    cdb_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .fu_done_valid (fu_done_valid),
        .fu_done_pr    (fu_done_pr),
        .fu_done_rob   (fu_done_rob),
        .fu_done_ready (fu_done_ready),
        .cdb_t         (cdb_t),
        .cdb_rob_valid (cdb_rob_valid),
        .cdb_rob_idx   (cdb_rob_idx)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which sources hold a result, and where the scan starts.
    bit               m_v   [N_SRC];
    int               m_pr  [N_SRC];
    int               m_rob [N_SRC];
    int               m_ptr;
    int               exp_t   [CDB_W];
    int               exp_rob [CDB_W];
    bit               exp_rv  [CDB_W];
    logic [N_SRC-1:0] m_accept;
    int               wait_cnt [N_SRC];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven by the caller.
    task automatic step();
        int               grant_src[$];
        logic [N_SRC-1:0] granted;
        logic [N_SRC-1:0] exp_ready;
        int               max_wait;
        CDB_T_PACKET      et;
        logic [CDB_W-1:0] erv;
        logic [CDB_W-1:0][ROBW-1:0] eidx;

        #1;
        granted = '0;
        for (int n = 0; n < N_SRC; n++) begin
            int s;
            s = (m_ptr + n) % N_SRC;
            if (m_v[s] && grant_src.size() < CDB_W) begin
                grant_src.push_back(s);
                granted[s] = 1'b1;
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            exp_ready[i] = !squash && (!m_v[i] || granted[i]);
        end

        if (!reset) begin
            check("ready", fu_done_ready, exp_ready);
            max_wait = 0;
            for (int i = 0; i < N_SRC; i++) begin
                if (fu_done_valid[i] && !fu_done_ready[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            check("starve_bound", max_wait <= 3, 1);
        end

        m_accept = fu_done_valid & exp_ready;
        for (int k = 0; k < CDB_W; k++) begin
            exp_t[k] = 0; exp_rob[k] = 0; exp_rv[k] = 0;
        end
        if (reset || squash) begin
            for (int i = 0; i < N_SRC; i++) m_v[i] = 0;
            m_ptr = 0;
        end else begin
            for (int k = 0; k < grant_src.size(); k++) begin
                exp_t[k]   = m_pr[grant_src[k]];
                exp_rob[k] = m_rob[grant_src[k]];
                exp_rv[k]  = 1;
            end
            if (grant_src.size() > 0) m_ptr = (grant_src[$] + 1) % N_SRC;
            for (int i = 0; i < N_SRC; i++) begin
                if (granted[i]) m_v[i] = 0;
                if (m_accept[i]) begin
                    m_v[i]   = 1;
                    m_pr[i]  = int'(fu_done_pr[i]);
                    m_rob[i] = int'(fu_done_rob[i]);
                end
            end
        end

        @(posedge clock);
        #1;
        et = '{t2: PRW'(exp_t[2]), t1: PRW'(exp_t[1]), t0: PRW'(exp_t[0])};
        for (int k = 0; k < CDB_W; k++) begin
            erv[k]  = exp_rv[k];
            eidx[k] = ROBW'(exp_rob[k]);
        end
        check("cdb_t", cdb_t, et);
        check("cdb_rob_valid", cdb_rob_valid, erv);
        check("cdb_rob_idx", cdb_rob_idx, eidx);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [N_SRC-1:0]  hold_v;
    int                tag33_cnt;

    initial begin
        reset = 1'b1; squash = 1'b0;
        fu_done_valid = '0; fu_done_pr = '0; fu_done_rob = '0;
        m_ptr = 0; m_accept = '0;
        for (int i = 0; i < N_SRC; i++) begin
            m_v[i] = 0; m_pr[i] = 0; m_rob[i] = 0; wait_cnt[i] = 0;
        end
        step(); step();
        reset = 1'b0;

        // Idle after reset
        step();
        check("idle_ready", fu_done_ready, 8'hFF);
        check("idle_cdb_t", cdb_t, 0);
        check("idle_rob_valid", cdb_rob_valid, 0);

        // Single completion from ALU_2
        fu_done_valid[S_ALU_2] = 1'b1; fu_done_pr[S_ALU_2] = 6'd5; fu_done_rob[S_ALU_2] = 5'd3;
        step();
        fu_done_valid = '0;
        step();
        check("single_t0", cdb_t.t0, 5);
        check("single_idx0", cdb_rob_idx[0], 3);
        check("single_rv", cdb_rob_valid, 3'b001);
        check("single_t1t2", {cdb_t.t1, cdb_t.t2}, 0);

        // All eight sources saturated, tags index+1, scan starting at 0
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            fu_done_pr[i] = PRW'(i + 1); fu_done_rob[i] = ROBW'(i);
        end
        fu_done_valid = '1;
        step();
        check("sat_ready_c1", fu_done_ready, 8'h07);
        step();
        check("sat_tags_c2", {cdb_t.t0, cdb_t.t1, cdb_t.t2}, {6'd1, 6'd2, 6'd3});
        check("sat_ready_c2", fu_done_ready, 8'h38);
        step();
        check("sat_tags_c3", {cdb_t.t0, cdb_t.t1, cdb_t.t2}, {6'd4, 6'd5, 6'd6});
        check("sat_ready_c3", fu_done_ready, 8'hC1);
        step();
        check("sat_tags_c4", {cdb_t.t0, cdb_t.t1, cdb_t.t2}, {6'd7, 6'd8, 6'd1});
        fu_done_valid = '0;
        repeat (4) step();

        // Back-to-back results from MULT_1
        fu_done_valid[S_MULT_1] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            fu_done_pr[S_MULT_1] = PRW'(10 + n); fu_done_rob[S_MULT_1] = ROBW'(n);
            check("b2b_ready", fu_done_ready[S_MULT_1], 1);
            step();
            if (n > 0) check("b2b_t0", cdb_t.t0, 10 + n - 1);
        end
        fu_done_valid = '0;
        step();
        check("b2b_t0_last", cdb_t.t0, 12);
        repeat (2) step();

        // Backpressure on sources 0..3
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fu_done_valid[i] = 1'b1; fu_done_pr[i] = PRW'(20 + i); fu_done_rob[i] = ROBW'(i);
        end
        step();
        for (int i = 0; i < 4; i++) fu_done_pr[i] = PRW'(30 + i);
        check("bp_ready3_low", fu_done_ready[3], 0);
        tag33_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            for (int i = 0; i < 4; i++) if (m_accept[i]) fu_done_valid[i] = 1'b0;
            if (cdb_t.t0 == 6'd33) tag33_cnt++;
            if (cdb_t.t1 == 6'd33) tag33_cnt++;
            if (cdb_t.t2 == 6'd33) tag33_cnt++;
        end
        check("bp_tag33_once", tag33_cnt, 1);

        // Squash with five buffers full
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fu_done_valid[i] = 1'b1; fu_done_pr[i] = PRW'(40 + i); fu_done_rob[i] = ROBW'(i);
        end
        step();
        squash = 1'b1;
        for (int i = 0; i < N_SRC; i++) begin
            fu_done_pr[i] = PRW'(50 + i); fu_done_rob[i] = ROBW'(i + 8);
        end
        fu_done_valid = '1;
        #1;
        check("squash_ready", fu_done_ready, 0);
        step();
        squash = 1'b0;
        check("squash_cdb_t", cdb_t, 0);
        fu_done_valid = '0;
        step();
        check("squash_no_accept", cdb_rob_valid, 0);
        for (int i = 0; i < N_SRC; i++) fu_done_pr[i] = PRW'(60 + i);
        fu_done_valid = '1;
        step();
        fu_done_valid = '0;
        step();
        check("squash_ptr0_t0", cdb_t.t0, 60);
        repeat (4) step();

        // Random traffic with FU hold semantics, occasional squash/reset
        hold_v = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (!hold_v[i] && $urandom_range(0, 99) < 55) begin
                    hold_v[i]      = 1'b1;
                    fu_done_pr[i]  = PRW'($urandom_range(0, 63));
                    fu_done_rob[i] = ROBW'($urandom_range(0, 31));
                end
            end
            fu_done_valid = hold_v;
            squash = ($urandom_range(0, 99) < 3);
            reset  = ($urandom_range(0, 199) < 1);
            step();
            hold_v = hold_v & ~m_accept;
        end
        squash = 1'b0; reset = 1'b0; fu_done_valid = '0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Completion-side producer of the CDB tag broadcast that the reservation station consumes.
- Collects finished results from the 8 function units: ALU_1..3, LS_1..2, MULT_1..2 and BRANCH.
- Holds each result in a per-FU one-entry buffer and arbitrates up to 3 per cycle round-robin.
- Drives the registered 3-wide tag broadcast plus the ROB indices to mark complete.

Parameters:
- N_SRC, 8, number of FU completion sources; index order ALU_1, ALU_2, ALU_3, LS_1, LS_2, MULT_1, MULT_2, BRANCH.
- PRW, 6, physical register tag width; tag 0 means "no broadcast".
- ROBW, 5, ROB index width.
- CDB_W, 3, broadcast slots per cycle; fixed at 3 to match CDB_T_PACKET t0/t1/t2.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- squash, in, 1, mispredict flush; clears all held results.
- fu_done_valid, in, N_SRC, FU i presents a finished result.
- fu_done_pr, in, N_SRC x PRW, destination tag per source.
- fu_done_rob, in, N_SRC x ROBW, ROB index per source.
- fu_done_ready, out, N_SRC, source i may hand over this cycle; the FU must hold its result while this is low.
- cdb_t, out, CDB_T_PACKET (3 x PRW), broadcast tags t0/t1/t2; 0 = empty slot.
- cdb_rob_valid, out, 3, slot k carries a completion.
- cdb_rob_idx, out, 3 x ROBW, ROB index per slot.

Behaviour:
- Single clock domain: clock. reset is synchronous and active-high. Both fixed.
- Reset state:
  - All buffers invalid; rr_ptr = 0.
  - cdb_t = 0, cdb_rob_valid = 0, cdb_rob_idx = 0.
- Per-source buffer:
  - Contents: valid bit, pr, rob.
  - Transfer occurs when fu_done_valid[i] && fu_done_ready[i]; the buffer loads at the clock edge.
  - fu_done_ready[i] = ~buf_valid[i] | grant[i]. This is combinational, so granting and refilling in the same cycle is allowed with no bubble.
  - A granted buffer with no new transfer becomes invalid.
  - Throughput: 1 result per source per cycle when granted every cycle.
- Arbitration (combinational, on buffer contents only; never on same-cycle inputs):
  - Scan sources from rr_ptr upward, wrapping modulo N_SRC.
  - The first 3 valid buffers get slots 0, 1, 2 in scan order.
  - Fewer than 3 valid: the unused slots are empty.
- Latency:
  - FU handover in cycle N; earliest grant in cycle N+1.
  - Tag visible on cdb_t in cycle N+2 (registered output).
- Output register:
  - Slot k granted: t_k <= buf.pr, cdb_rob_valid[k] <= 1, cdb_rob_idx[k] <= buf.rob.
  - Slot k not granted: t_k <= 0, cdb_rob_valid[k] <= 0, cdb_rob_idx[k] <= 0.
- Round-robin pointer update:
  - If any grant: rr_ptr <= (index of last granted source + 1) mod N_SRC.
  - Otherwise rr_ptr is unchanged.
  - Wrap from 7 to 0 is exact; rr_ptr width is clog2(N_SRC).
- Tag 0 entry: a buffered pr of 0 is still granted (ROB completion needed), but its t_k is 0. Consumers treat this as no wakeup.
- squash (takes priority over normal operation):
  - Next cycle all buffers are invalid and outputs are 0.
  - fu_done_ready is forced to 0 during the squash cycle; no transfers are accepted.
  - rr_ptr is reset to 0.
- reset or squash asserted mid-stream discards held results; there is no partial broadcast.
- Starvation bound: any valid buffer is granted within ceil(N_SRC/CDB_W) = 3 cycles.

Decomposition:
- Shared package:
  - CDB_T_PACKET (existing).
  - FU index enum matching the source order.
  - FU_DONE_PACKET {valid, pr, rob}.
  - N_SRC and CDB_W constants.
- One sub-module: rr_select3.
  - Combinational: rotate the valid vector by rr_ptr, take the 3 lowest set bits with cascaded priority selectors, rotate back.
  - Outputs: 3 one-hot grants, grant-valid bits, and the last-granted index.

Test Plan:
1. Reset, then idle: cdb_t == 0, cdb_rob_valid == 0, fu_done_ready == 8'hFF.
2. Single completion: ALU_2 valid with pr=5, rob=3 in cycle 0. Expect cycle 2: t0=5, cdb_rob_idx[0]=3, cdb_rob_valid=3'b001, t1=t2=0.
3. All 8 valid every cycle with constant tags 1..8 (pr = index+1), rr_ptr=0:
   - Cycle 2 broadcasts tags {1,2,3}, cycle 3 {4,5,6}, cycle 4 {7,8,1}.
   - Every source is granted within 3 cycles.
   - fu_done_ready equals the grant vector.
4. Back-to-back from one source: MULT_1 valid every cycle with pr=10,11,12. Expect fu_done_ready[5] held at 1 and t0 = 10, 11, 12 in consecutive cycles with no bubble.
5. Backpressure: sources 0..3 valid and held, data unchanged while ready is low:
   - Source 3 ready stays 0 until it is granted.
   - Its pr is broadcast exactly once, one cycle after its grant.
6. Squash with 5 buffers full: next cycle all buffers are empty, cdb_t == 0 and rr_ptr == 0. Inputs presented during the squash cycle are not accepted.
